// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD conversion arbiter and its double-dabble core.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    CONVERT = 2'd2,
    DELIVER = 2'd3
  } state_e;

  localparam int BCD_DIGIT_WIDTH = 4;

  // A digit greater than this is corrected by adding 3 before the shift.
  localparam logic [BCD_DIGIT_WIDTH-1:0] ADD3_THRESHOLD = 4'd4;
  localparam logic [BCD_DIGIT_WIDTH-1:0] ADD3_VALUE     = 4'd3;

  // Decimal digits needed to represent 2^bin_width - 1.
  function automatic int min_bcd_digits(input int bin_width);
    longint unsigned max_val;
    int n;
    max_val = (64'd1 << bin_width) - 64'd1;
    n = 1;
    while (max_val >= 64'd10) begin
      max_val = max_val / 64'd10;
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_conversion_arbiter_if.sv
// Client-side bus of the BCD conversion arbiter.
// slave: arbiter side, master: the collection of clients.
interface bcd_conversion_arbiter_if #(
  parameter int NUM_REQUESTERS   = 4,
  parameter int BINARY_DATA_SIZE = 8,
  parameter int BCD_DIGITS       = 3
);
  logic [NUM_REQUESTERS-1:0]                  req;
  logic [NUM_REQUESTERS*BINARY_DATA_SIZE-1:0] req_data;
  logic [NUM_REQUESTERS-1:0]                  ack;
  logic [NUM_REQUESTERS-1:0]                  bcd_valid;
  logic [4*BCD_DIGITS-1:0]                    bcd_data;
  logic                                       busy;

  modport slave (
    input  req, req_data,
    output ack, bcd_valid, bcd_data, busy
  );

  modport master (
    output req, req_data,
    input  ack, bcd_valid, bcd_data, busy
  );
endinterface

// File: rtl/bcd_double_dabble_core.sv
// Iterative binary-to-BCD converter (shift/add-3), one step per clock.
// The start cycle already performs the first step on the incoming operand,
// so done pulses after exactly BINARY_DATA_SIZE steps with bcd valid alongside.
module bcd_double_dabble_core
  import bcd_pkg::*;
#(
  parameter int BINARY_DATA_SIZE = 8,
  parameter int BCD_DIGITS       = 3
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [BINARY_DATA_SIZE-1:0]           operand,
  output logic                                  done,
  output logic [BCD_DIGITS*BCD_DIGIT_WIDTH-1:0] bcd
);

  localparam int BW = BCD_DIGITS * BCD_DIGIT_WIDTH;
  localparam int CW = $clog2(BINARY_DATA_SIZE + 1);

  logic [BW-1:0]               bcd_q, bcd_d, src_bcd, adj_bcd;
  logic [BINARY_DATA_SIZE-1:0] bin_q, bin_d, src_bin;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        done_q, done_d;

  // One double-dabble step: correct every digit, then shift the pair left.
  always_comb begin
    src_bcd = start ? '0 : bcd_q;
    src_bin = start ? operand : bin_q;
    adj_bcd = src_bcd;
    for (int dg = 0; dg < BCD_DIGITS; dg++) begin
      if (src_bcd[dg*BCD_DIGIT_WIDTH +: BCD_DIGIT_WIDTH] > ADD3_THRESHOLD)
        adj_bcd[dg*BCD_DIGIT_WIDTH +: BCD_DIGIT_WIDTH] =
          src_bcd[dg*BCD_DIGIT_WIDTH +: BCD_DIGIT_WIDTH] + ADD3_VALUE;
    end
  end

  // Step sequencing: load on start, count the remaining steps, pulse done on the last.
  always_comb begin
    bcd_d  = bcd_q;
    bin_d  = bin_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (start) begin
      bcd_d = {adj_bcd[BW-2:0], src_bin[BINARY_DATA_SIZE-1]};
      bin_d = {src_bin[BINARY_DATA_SIZE-2:0], 1'b0};
      cnt_d = CW'(BINARY_DATA_SIZE - 1);
    end else if (cnt_q != '0) begin
      bcd_d  = {adj_bcd[BW-2:0], src_bin[BINARY_DATA_SIZE-1]};
      bin_d  = {src_bin[BINARY_DATA_SIZE-2:0], 1'b0};
      cnt_d  = cnt_q - 1'b1;
      done_d = (cnt_q == CW'(1));
    end
  end

  // Datapath and step counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q  <= '0;
      bin_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      bcd_q  <= bcd_d;
      bin_q  <= bin_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/bcd_conversion_arbiter.sv
// Shares one double-dabble core among NUM_REQUESTERS clients.
// Optional macro BCD_ARB_FIXED_PRIORITY_EN: lowest-index request always wins
// and the round-robin pointer disappears; timing is unchanged.
module bcd_conversion_arbiter
  import bcd_pkg::*;
#(
  parameter int NUM_REQUESTERS   = 4,
  parameter int BINARY_DATA_SIZE = 8,
  parameter int BCD_DIGITS       = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  bcd_conversion_arbiter_if.slave  bus
);

  localparam int N     = NUM_REQUESTERS;
  localparam int W     = BINARY_DATA_SIZE;
  localparam int BW    = BCD_DIGITS * BCD_DIGIT_WIDTH;
  localparam int WIN_W = $clog2(N);

  // Configuration sanity: the result must never truncate.
  if (BCD_DIGITS < min_bcd_digits(BINARY_DATA_SIZE)) begin : g_bad_digits
    $error("BCD_DIGITS too small for BINARY_DATA_SIZE");
  end
  if (N < 2 || N > 8) begin : g_bad_n
    $error("NUM_REQUESTERS out of range 2..8");
  end

  state_e           state_q, state_d;
  logic [WIN_W-1:0] winner_q, winner_d, sel_idx;
  logic [N-1:0]     ack_q, ack_d, bcd_valid_q, bcd_valid_d;
  logic [BW-1:0]    bcd_data_q, bcd_data_d;
  logic             busy_q, busy_d;
  logic             any_req;
  logic             core_start, core_done;
  logic [W-1:0]     core_operand;
  logic [BW-1:0]    core_bcd;

`ifdef BCD_ARB_FIXED_PRIORITY_EN
  // Lowest asserted index wins.
  always_comb begin
    any_req = |bus.req;
    sel_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.req[i]) sel_idx = WIN_W'(i);
    end
  end
`else
  logic [WIN_W-1:0] rr_ptr_q, rr_ptr_d;
  int               rr_idx;
  logic             found;

  // Round-robin: first asserted request at or after rr_ptr, wrapping.
  always_comb begin
    any_req = |bus.req;
    sel_idx = '0;
    found   = 1'b0;
    rr_idx  = 0;
    for (int i = 0; i < N; i++) begin
      rr_idx = (int'(rr_ptr_q) + i) % N;
      if (!found && bus.req[rr_idx]) begin
        found   = 1'b1;
        sel_idx = WIN_W'(rr_idx);
      end
    end
  end

  // Pointer moves past the client just served.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == DELIVER)
      rr_ptr_d = (winner_q == WIN_W'(N - 1)) ? '0 : winner_q + 1'b1;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      winner_q <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
    end
  end

  // FSM next state; the winner is latched only on leaving IDLE.
  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d  = GRANT;
          winner_d = sel_idx;
        end
      end
      GRANT:   state_d = CONVERT;
      CONVERT: if (core_done) state_d = DELIVER;
      DELIVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state.
  always_comb begin
    ack_d       = '0;
    bcd_valid_d = '0;
    bcd_data_d  = bcd_data_q;
    busy_d      = (state_d != IDLE);
    if (state_d == GRANT) ack_d[winner_d] = 1'b1;
    if (state_d == DELIVER) begin
      bcd_valid_d[winner_d] = 1'b1;
      bcd_data_d            = core_bcd;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q       <= '0;
      bcd_valid_q <= '0;
      bcd_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      ack_q       <= ack_d;
      bcd_valid_q <= bcd_valid_d;
      bcd_data_q  <= bcd_data_d;
      busy_q      <= busy_d;
    end
  end

  assign core_start   = (state_q == GRANT);
  assign core_operand = bus.req_data[int'(winner_q)*W +: W];

  bcd_double_dabble_core #(
    .BINARY_DATA_SIZE (W),
    .BCD_DIGITS       (BCD_DIGITS)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (core_start),
    .operand (core_operand),
    .done    (core_done),
    .bcd     (core_bcd)
  );

  assign bus.ack       = ack_q;
  assign bus.bcd_valid = bcd_valid_q;
  assign bus.bcd_data  = bcd_data_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_bcd_conversion_arbiter.sv
// Directed bench for bcd_conversion_arbiter (4 clients, 8-bit operands, 3 digits).
module tb_bcd_conversion_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int BD = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req_r = '0;
  logic [N*W-1:0] data_r = '0;

  int n_chk  = 0;
  int n_fail = 0;

  logic [11:0] exp_bcd [N];
  int g_cli[$];
  int g_cyc[$];
  int v_first;

  always #5 clk = ~clk;

  bcd_conversion_arbiter_if #(.NUM_REQUESTERS(N), .BINARY_DATA_SIZE(W), .BCD_DIGITS(BD)) bus ();

  assign bus.req      = req_r;
  assign bus.req_data = data_r;

  bcd_conversion_arbiter #(.NUM_REQUESTERS(N), .BINARY_DATA_SIZE(W), .BCD_DIGITS(BD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs from a negedge where requests were just applied (cycle 0); records
  // grants and checks every bcd_valid against the client last granted.
  task automatic serve(input int ngr, input logic [N-1:0] hold);
    int cyc;
    int last;
    int nval;
    cyc = 0; last = 0; nval = 0; v_first = -1;
    g_cli.delete(); g_cyc.delete();
    while (cyc < 200 && nval < ngr) begin
      @(negedge clk);
      cyc++;
      if (bus.ack != '0) begin
        chk("ack_onehot", $countones(bus.ack), 1);
        for (int i = 0; i < N; i++) if (bus.ack[i]) last = i;
        g_cli.push_back(last);
        g_cyc.push_back(cyc);
        if (!hold[last]) req_r[last] = 1'b0;
        if (g_cli.size() == ngr) req_r = '0;
      end
      if (bus.bcd_valid != '0) begin
        if (v_first < 0) v_first = cyc;
        chk("valid_owner", bus.bcd_valid, 32'(1) << last);
        chk("bcd_data", bus.bcd_data, exp_bcd[last]);
        nval++;
      end
    end
    if (nval != ngr) chk("serve_timeout", nval, ngr);
  endtask

  task automatic single(input int c, input logic [7:0] op, input logic [11:0] eb);
    data_r[c*W +: W] = op;
    exp_bcd[c] = eb;
    req_r[c] = 1'b1;
    serve(1, '0);
    chk("single_client", g_cli[0], c);
    chk("ack_cycle", g_cyc[0], 1);
    chk("valid_cycle", v_first, 10);
    @(negedge clk);
    chk("busy_after", bus.busy, 0);
    chk("data_hold", bus.bcd_data, eb);
  endtask

  logic [7:0]  ops  [6] = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd128};
  logic [11:0] exps [6] = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h128};

  initial begin
    int nv;
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ack", bus.ack, 0);
    chk("rst_valid", bus.bcd_valid, 0);
    chk("rst_data", bus.bcd_data, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single client, max operand
    single(0, 8'd255, 12'h255);

    // operand boundaries on client 2
    for (int k = 0; k < 6; k++) single(2, ops[k], exps[k]);

    // fresh reset so the pointer starts at 0
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // all four simultaneously
    data_r = {8'd240, 8'd163, 8'd58, 8'd7};
    exp_bcd[0] = 12'h007; exp_bcd[1] = 12'h058; exp_bcd[2] = 12'h163; exp_bcd[3] = 12'h240;
    req_r = 4'b1111;
    serve(4, '0);
    for (int k = 0; k < 4; k++) begin
      chk("all_order", g_cli[k], k);
      chk("all_cycle", g_cyc[k], 1 + 11*k);
    end
    @(negedge clk);

`ifdef BCD_ARB_FIXED_PRIORITY_EN
    // fixed priority: 0 held beats 2
    data_r[0 +: W] = 8'd42;  exp_bcd[0] = 12'h042;
    data_r[16 +: W] = 8'd201; exp_bcd[2] = 12'h201;
    req_r = 4'b0101;
    serve(3, 4'b0101);
    for (int k = 0; k < 3; k++) chk("fixed_order", g_cli[k], 0);
    @(negedge clk);
    req_r[2] = 1'b1;
    serve(1, '0);
    chk("fixed_late", g_cli[0], 2);
    @(negedge clk);
`else
    // clients 1 and 3 both held: strict alternation
    data_r[8 +: W] = 8'd42;  exp_bcd[1] = 12'h042;
    data_r[24 +: W] = 8'd201; exp_bcd[3] = 12'h201;
    req_r = 4'b1010;
    serve(4, 4'b1010);
    chk("alt_0", g_cli[0], 1);
    chk("alt_1", g_cli[1], 3);
    chk("alt_2", g_cli[2], 1);
    chk("alt_3", g_cli[3], 3);
    @(negedge clk);
`endif

    // move the pointer off 0, then abort a conversion with reset
    single(1, 8'd64, 12'h064);
    data_r[16 +: W] = 8'd77;
    req_r[2] = 1'b1;
    nv = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("abort_ack", bus.ack, 4'b0100);
        req_r[2] = 1'b0;
      end
    end
    rst_n = 1'b0;
    #1;
    chk("abort_ack0", bus.ack, 0);
    chk("abort_valid0", bus.bcd_valid, 0);
    chk("abort_data0", bus.bcd_data, 0);
    chk("abort_busy0", bus.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.bcd_valid != '0) nv++;
    end
    chk("abort_no_valid", nv, 0);

    // after reset the pointer is 0: client 0 beats client 3
    data_r[0 +: W] = 8'd123; exp_bcd[0] = 12'h123;
    data_r[24 +: W] = 8'd5;  exp_bcd[3] = 12'h005;
    req_r = 4'b1001;
    serve(2, '0);
    chk("post_rst_first", g_cli[0], 0);
    chk("post_rst_second", g_cli[1], 3);
    chk("post_rst_ack_cyc", g_cyc[0], 1);
    chk("post_rst_valid_cyc", v_first, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
